// File: rtl/rr_mux.sv
// N-channel arbitrating multiplexer with a single registered output beat.
// The grant comes from a round-robin pointer, fixed priority or an external select.
module rr_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_ch,
  output logic [15:0]        xfer_cnt
);

  logic [WIDTH-1:0] ch_data [N];
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SW-1:0]    out_ch_reg;
  logic [SW-1:0]    ptr_reg;
  logic [15:0]      xfer_cnt_reg;

  logic             load_en;
  logic             grant_any;
  logic [SW-1:0]    grant_idx;
  logic             grant_fire;

  assign load_en    = !out_valid_reg || out_ready;
  assign grant_fire = grant_any && load_en && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = grant_fire && (grant_idx == SW'(gi));
    end
  endgenerate

  // Loops scan from the least preferred candidate down, so the most
  // preferred eligible channel is the last one written.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (MODE == 2) begin
      if ((int'(sel) < N) && in_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_reg) + k) % N;
        if (in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = SW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
      xfer_cnt_reg  <= '0;
    end else begin
      if (out_valid_reg && out_ready)
        xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
      if (load_en) begin
        out_valid_reg <= grant_any;
        if (grant_any) begin
          out_data_reg <= ch_data[grant_idx];
          out_ch_reg   <= grant_idx;
        end
      end
      if (MODE == 0 && grant_fire)
        ptr_reg <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: round-robin, fixed priority, external select,
// backpressure, counter wrap, mid-stream reset and the single-channel case.
module tb_rr_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Round-robin instance
  logic [31:0] d0_in_data;
  logic [3:0]  d0_in_valid, d0_in_ready;
  logic [1:0]  d0_sel, d0_out_ch;
  logic [7:0]  d0_out_data;
  logic        d0_out_valid, d0_out_ready;
  logic [15:0] d0_xfer_cnt;
  // Fixed priority instance
  logic [31:0] d1_in_data;
  logic [3:0]  d1_in_valid, d1_in_ready;
  logic [1:0]  d1_sel, d1_out_ch;
  logic [7:0]  d1_out_data;
  logic        d1_out_valid, d1_out_ready;
  logic [15:0] d1_xfer_cnt;
  // External select instance
  logic [31:0] d2_in_data;
  logic [3:0]  d2_in_valid, d2_in_ready;
  logic [1:0]  d2_sel, d2_out_ch;
  logic [7:0]  d2_out_data;
  logic        d2_out_valid, d2_out_ready;
  logic [15:0] d2_xfer_cnt;
  // Single channel instance
  logic [7:0]  d3_in_data;
  logic [0:0]  d3_in_valid, d3_in_ready;
  logic [0:0]  d3_sel, d3_out_ch;
  logic [7:0]  d3_out_data;
  logic        d3_out_valid, d3_out_ready;
  logic [15:0] d3_xfer_cnt;

  rr_mux #(.WIDTH(8), .N(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_ch(d0_out_ch),
    .xfer_cnt(d0_xfer_cnt));

  rr_mux #(.WIDTH(8), .N(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_ch(d1_out_ch),
    .xfer_cnt(d1_xfer_cnt));

  rr_mux #(.WIDTH(8), .N(4), .MODE(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_ch(d2_out_ch),
    .xfer_cnt(d2_xfer_cnt));

  rr_mux #(.WIDTH(8), .N(1), .MODE(0)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .sel(d3_sel), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_ch(d3_out_ch),
    .xfer_cnt(d3_xfer_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d0_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    d1_in_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    d2_in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    d3_in_data = 8'h5A;
    d0_in_valid = 4'b1111; d1_in_valid = 4'b0000; d2_in_valid = 4'b0000; d3_in_valid = 1'b0;
    d0_sel = '0; d1_sel = '0; d2_sel = '0; d3_sel = '0;
    d0_out_ready = 1'b1; d1_out_ready = 1'b1; d2_out_ready = 1'b1; d3_out_ready = 1'b1;

    // Reset: no grants even with requests pending, outputs cleared
    #1;
    chk("rst_in_ready", 32'(d0_in_ready), 32'h0);
    tick(); tick();
    chk("rst_out_valid", 32'(d0_out_valid), 32'h0);
    chk("rst_out_data", 32'(d0_out_data), 32'h0);
    chk("rst_out_ch", 32'(d0_out_ch), 32'h0);
    chk("rst_xfer_cnt", 32'(d0_xfer_cnt), 32'h0);
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(d0_in_ready), 32'h1);

    // Round-robin over all four channels
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_ch_%0d", k), 32'(d0_out_ch), 32'(k % 4));
      chk($sformatf("rr_data_%0d", k), 32'(d0_out_data), 32'(8'hA0 + (k % 4)));
    end
    chk("rr_xfer_cnt", 32'(d0_xfer_cnt), 32'd4);

    // Pointer wrap with sparse requests: 3, 0, 3
    d0_in_valid = 4'b1001;
    tick(); chk("wrap_ch_a", 32'(d0_out_ch), 32'd3);
    tick(); chk("wrap_ch_b", 32'(d0_out_ch), 32'd0);
    tick(); chk("wrap_ch_c", 32'(d0_out_ch), 32'd3);
    chk("wrap_xfer_cnt", 32'(d0_xfer_cnt), 32'd7);

    // Backpressure: beat held, no grants, counter frozen
    d0_out_ready = 1'b0;
    d0_in_valid  = 4'b1111;
    #1;
    chk("bp_in_ready_0", 32'(d0_in_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) d0_in_valid = 4'b0110;
      #1;
      chk($sformatf("bp_ch_%0d", k), 32'(d0_out_ch), 32'd3);
      chk($sformatf("bp_data_%0d", k), 32'(d0_out_data), 32'hA3);
      chk($sformatf("bp_ready_%0d", k), 32'(d0_in_ready), 32'h0);
      chk($sformatf("bp_cnt_%0d", k), 32'(d0_xfer_cnt), 32'd7);
    end
    d0_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(d0_in_ready), 32'b0010);
    tick();
    chk("bp_release_cnt", 32'(d0_xfer_cnt), 32'd8);
    chk("bp_release_ch", 32'(d0_out_ch), 32'd1);

    // Reset with a beat held and pointer at 2
    chk("pre_rst_valid", 32'(d0_out_valid), 32'h1);
    rst = 1'b1;
    d0_in_valid = 4'b1111;
    tick();
    chk("mid_rst_valid", 32'(d0_out_valid), 32'h0);
    chk("mid_rst_cnt", 32'(d0_xfer_cnt), 32'h0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ptr0", 32'(d0_in_ready), 32'b0001);

    // Counter wrap: first load carries no output transfer
    tick();
    chk("cnt_first_ch", 32'(d0_out_ch), 32'd0);
    repeat (65535) tick();
    chk("cnt_ffff", 32'(d0_xfer_cnt), 32'hFFFF);
    tick();
    chk("cnt_wrap", 32'(d0_xfer_cnt), 32'h0);
    chk("cnt_wrap_valid", 32'(d0_out_valid), 32'h1);

    // Fixed priority: channel 1 beats channel 2 every time
    d1_in_valid = 4'b0110;
    #1;
    chk("fp_ready_0", 32'(d1_in_ready), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fp_ch_%0d", k), 32'(d1_out_ch), 32'd1);
      chk($sformatf("fp_data_%0d", k), 32'(d1_out_data), 32'hB1);
      chk($sformatf("fp_ready_%0d", k + 1), 32'(d1_in_ready), 32'b0010);
    end
    d1_in_valid = 4'b0000;
    tick();
    chk("fp_drain_valid", 32'(d1_out_valid), 32'h0);
    chk("fp_xfer_cnt", 32'(d1_xfer_cnt), 32'd3);

    // External select: channel 2, then select an idle channel 3
    d2_sel = 2'd2;
    d2_in_valid = 4'b0100;
    #1;
    chk("sel_ready", 32'(d2_in_ready), 32'b0100);
    tick();
    chk("sel_ch", 32'(d2_out_ch), 32'd2);
    chk("sel_data", 32'(d2_out_data), 32'hC2);
    chk("sel_valid", 32'(d2_out_valid), 32'h1);
    d2_sel = 2'd3;
    #1;
    chk("sel_idle_ready", 32'(d2_in_ready), 32'h0);
    tick();
    chk("sel_idle_valid", 32'(d2_out_valid), 32'h0);
    chk("sel_idle_ready2", 32'(d2_in_ready), 32'h0);

    // Single channel behaves as a register slice
    d3_in_valid = 1'b1;
    #1;
    chk("n1_ready", 32'(d3_in_ready), 32'h1);
    tick();
    chk("n1_data", 32'(d3_out_data), 32'h5A);
    chk("n1_ch", 32'(d3_out_ch), 32'h0);
    chk("n1_valid", 32'(d3_out_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data width per channel in bits (>=1).
REQ-002 The block SHALL take parameter N, default 4, as the number of input channels (>=1); SW = max(1, clog2(N)).
REQ-003 The block SHALL take parameter MODE, default 0, as the arbitration mode: 0 round-robin, 1 fixed priority (lowest index wins), 2 external select.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, width N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, width N: per-channel valid.
REQ-008 The block SHALL have port in_ready, output, width N: per-channel ready, at most one bit high per cycle.
REQ-009 The block SHALL have port sel, input, width SW: channel select, used only when MODE=2.
REQ-010 The block SHALL have port out_data, output, width WIDTH: registered output data.
REQ-011 The block SHALL have port out_valid, output, width 1: output register holds a beat.
REQ-012 The block SHALL have port out_ready, input, width 1: downstream accepts the beat.
REQ-013 The block SHALL have port out_ch, output, width SW: source channel of the beat in out_data.
REQ-014 The block SHALL have port xfer_cnt, output, width 16: count of accepted output beats, wrapping.

Function
REQ-015 A transfer SHALL occur on input i when in_valid[i] && in_ready[i], and on the output when out_valid && out_ready.
REQ-016 The output register SHALL load when load_en = !out_valid || out_ready.
REQ-017 in_ready SHALL be combinational: in_ready[g]=load_en for the single granted channel g, and 0 elsewhere; no valid-to-ready loop is permitted on the output side beyond out_ready.
REQ-018 In MODE 0, g SHALL be the first i with in_valid[i], scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 In MODE 0, after an input transfer from channel k, ptr SHALL become k+1, wrapping N-1 to 0; otherwise ptr holds.
REQ-020 In MODE 1, g SHALL be the lowest i with in_valid[i], and ptr is unused.
REQ-021 In MODE 2, g=sel SHALL apply if sel<N and in_valid[sel]; if sel>=N there is no grant and all in_ready are 0.
REQ-022 If no eligible in_valid exists, all in_ready SHALL be 0, and out_valid clears if the current beat is taken (or stays 0).
REQ-023 On an input transfer, out_data<=in_data[g], out_ch<=g and out_valid<=1 SHALL take effect next cycle; latency is 1 cycle.
REQ-024 Simultaneous output transfer and input transfer SHALL replace the beat in the same edge, giving 1 beat/cycle sustained throughput.
REQ-025 While out_valid && !out_ready, out_data and out_ch SHALL be held stable, and all in_ready are 0.
REQ-026 xfer_cnt SHALL increment by 1 per output transfer, modulo 2^16 (0xFFFF -> 0x0000).
REQ-027 When N=1, the block SHALL degenerate to a 1-entry register slice with out_ch=0 in all modes.
REQ-028 Changes on sel or in_valid while stalled SHALL have no effect on the held beat.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_ch=0, ptr=0 and xfer_cnt=0.
REQ-030 While rst=1, all in_ready SHALL be 0, so no input transfer occurs.
REQ-031 Reset asserted mid-operation SHALL discard any held beat without an output transfer being counted.
REQ-032 The first grant after reset in MODE 0 SHALL start scanning from channel 0.

Verification
REQ-033 The bench SHALL check MODE0, N=4, WIDTH=8, out_ready=1, in_valid=4'b1111, data i=8'hA0+i -> out_ch sequence 0,1,2,3,0 on consecutive cycles, with out_data A0,A1,A2,A3,A0.
REQ-034 The bench SHALL check MODE0, in_valid=4'b1001 after a grant of 3 -> next grant 0, then 3 (pointer wrap).
REQ-035 The bench SHALL check MODE1, in_valid=4'b0110 held for 3 cycles -> out_ch=1 every beat, with in_ready=4'b0010.
REQ-036 The bench SHALL check MODE2, sel=2, in_valid=4'b0100, then sel=3'b... set to 3 with in_valid[3]=0 -> one beat from channel 2, then out_valid=0 and in_ready=0.
REQ-037 The bench SHALL check a backpressure case: out_ready=0 for 4 cycles with a beat held -> out_data/out_ch stable, in_ready=0, and xfer_cnt unchanged; after release, xfer_cnt +1.
REQ-038 The bench SHALL check xfer_cnt forced near wrap (0xFFFF reached by 65535 beats) -> the next beat gives 0x0000; rst=1 while out_valid=1 -> the next cycle has out_valid=0, xfer_cnt=0 and ptr=0.
